eth_fcs_append: RTL and testbench

ETH_FCS_APPEND -- requirements
Module: eth_fcs_append

---
 rtl/eth_fcs_append.sv | 208 ++++++++++++++++++++
 tb/tb_eth_fcs_append.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/eth_fcs_append.sv
// Ethernet FCS appender: forwards payload bytes, optionally zero-pads to MIN_LEN,
// then appends the CRC-32 FCS LSB first. Optional padding is enabled by `define FCS_PAD_EN.
module eth_fcs_append #(
    parameter int          MIN_LEN = 60,
    parameter logic [31:0] POLY    = 32'hEDB88320
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready,
    output logic       busy
);

`ifdef FCS_PAD_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PAD = 2'd2, FCS = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, FCS = 2'd3} state_t;
`endif

    // Reject nonsensical minimum lengths at elaboration time.
    if (MIN_LEN < 1) begin : g_min_len_chk
        $error("eth_fcs_append: MIN_LEN must be positive");
    end

    // One reflected CRC-32 byte update, data bits consumed LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] d);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) begin
                c = (c >> 1) ^ POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    // Select one FCS byte from the inverted CRC, least-significant byte first.
    function automatic logic [7:0] fcs_byte(input logic [31:0] fcs, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = fcs[7:0];
            2'd1:    b = fcs[15:8];
            2'd2:    b = fcs[23:16];
            2'd3:    b = fcs[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_t      state_r, state_nxt_s;
    logic [31:0] crc_r, crc_nxt_s;
    logic [1:0]  fcs_idx_r, fcs_idx_nxt_s;
    logic [7:0]  m_data_r, m_data_nxt_s;
    logic        m_valid_r, m_valid_nxt_s;
    logic        m_last_r, m_last_nxt_s;
    logic        busy_r, busy_nxt_s;
    logic        adv_s;
    logic        s_ready_s;
    logic        accept_s;

`ifdef FCS_PAD_EN
    localparam int CW = $clog2(MIN_LEN + 1);
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic [CW-1:0] cnt_inc_s;
    logic          pad_need_s;
    logic          pad_done_s;

    assign cnt_inc_s  = (cnt_r < CW'(MIN_LEN)) ? cnt_r + CW'(1) : cnt_r;
    assign pad_need_s = (cnt_r < CW'(MIN_LEN - 1));
    assign pad_done_s = (cnt_r >= CW'(MIN_LEN - 1));
`endif

    // The output register may load whenever it is empty or being drained.
    assign adv_s     = !m_valid_r || m_ready;
    assign s_ready_s = rst_n && ((state_r == IDLE) || (state_r == DATA)) && adv_s;
    assign accept_s  = s_valid && s_ready_s;

    // Next-state, CRC and output-register load logic.
    always_comb begin
        state_nxt_s   = state_r;
        crc_nxt_s     = crc_r;
        fcs_idx_nxt_s = fcs_idx_r;
        m_data_nxt_s  = m_data_r;
        m_valid_nxt_s = adv_s ? 1'b0 : m_valid_r;
        m_last_nxt_s  = adv_s ? 1'b0 : m_last_r;
`ifdef FCS_PAD_EN
        cnt_nxt_s     = cnt_r;
`endif
        case (state_r)
            IDLE, DATA: begin
                if (accept_s) begin
                    m_data_nxt_s  = s_data;
                    m_valid_nxt_s = 1'b1;
                    crc_nxt_s     = crc_byte(crc_r, s_data);
`ifdef FCS_PAD_EN
                    cnt_nxt_s     = cnt_inc_s;
`endif
                    if (s_last) begin
`ifdef FCS_PAD_EN
                        if (pad_need_s) begin
                            state_nxt_s = PAD;
                        end else begin
                            state_nxt_s = FCS;
                        end
`else
                        state_nxt_s = FCS;
`endif
                    end else begin
                        state_nxt_s = DATA;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
`ifdef FCS_PAD_EN
            PAD: begin
                if (adv_s) begin
                    m_data_nxt_s  = 8'h00;
                    m_valid_nxt_s = 1'b1;
                    crc_nxt_s     = crc_byte(crc_r, 8'h00);
                    cnt_nxt_s     = cnt_inc_s;
                    if (pad_done_s) begin
                        state_nxt_s = FCS;
                    end else begin
                        state_nxt_s = PAD;
                    end
                end else begin
                    state_nxt_s = PAD;
                end
            end
`endif
            FCS: begin
                if (adv_s) begin
                    m_data_nxt_s  = fcs_byte(~crc_r, fcs_idx_r);
                    m_valid_nxt_s = 1'b1;
                    m_last_nxt_s  = (fcs_idx_r == 2'd3);
                    fcs_idx_nxt_s = fcs_idx_r + 2'd1;
                    if (fcs_idx_r == 2'd3) begin
                        // Re-arm for the next frame; it may start next cycle.
                        state_nxt_s = IDLE;
                        crc_nxt_s   = 32'hFFFFFFFF;
`ifdef FCS_PAD_EN
                        cnt_nxt_s   = '0;
`endif
                    end else begin
                        state_nxt_s = FCS;
                    end
                end else begin
                    state_nxt_s = FCS;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                crc_nxt_s     = 32'hFFFFFFFF;
                fcs_idx_nxt_s = 2'd0;
            end
        endcase
        // Busy covers the whole frame including a final FCS byte still waiting downstream.
        busy_nxt_s = (state_nxt_s != IDLE) || (m_valid_nxt_s && m_last_nxt_s);
    end

    // State, CRC and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            crc_r     <= 32'hFFFFFFFF;
            fcs_idx_r <= 2'd0;
            m_data_r  <= 8'h00;
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            crc_r     <= crc_nxt_s;
            fcs_idx_r <= fcs_idx_nxt_s;
            m_data_r  <= m_data_nxt_s;
            m_valid_r <= m_valid_nxt_s;
            m_last_r  <= m_last_nxt_s;
            busy_r    <= busy_nxt_s;
        end
    end

`ifdef FCS_PAD_EN
    // Frame length counter used for padding decisions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end
`endif

    assign s_ready = s_ready_s;
    assign m_data  = m_data_r;
    assign m_valid = m_valid_r;
    assign m_last  = m_last_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_eth_fcs_append.sv
// Directed self-checking bench for eth_fcs_append (pad checks compile in with FCS_PAD_EN).
module tb_eth_fcs_append;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready = 1'b1;
    logic       busy;

    eth_fcs_append dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
        .m_ready(m_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         last_cyc = 0;
    int         acc_cyc = 0;
    bit         toggle_en = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [8:0] rx_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Collect transferred beats and check that stalled data holds.
    always @(negedge clk) begin
        if (prev_stall && rst_n) begin
            chk("stall_valid", {31'd0, m_valid}, 32'd1);
            chk("stall_data", {24'd0, m_data}, {24'd0, prev_data});
        end
        prev_stall <= m_valid && !m_ready;
        prev_data  <= m_data;
        if (m_valid && m_ready) begin
            rx_q.push_back({m_last, m_data});
            if (m_last) last_cyc <= cyc;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = toggle_en ? ~m_ready : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] d, input logic last);
        bit got;
        got = 1'b0;
        s_data = d; s_valid = 1'b1; s_last = last;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (s_ready) begin
                got = 1'b1;
                acc_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0; s_last = 1'b0;
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input logic [7:0] b[$]);
        for (int i = 0; i < b.size(); i++) send_byte(b[i], i == b.size() - 1);
    endtask

    task automatic wait_rx(input int n);
        for (int i = 0; i < 1000 && rx_q.size() < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag, input logic [7:0] pay[$], input logic [31:0] fcs);
        logic [7:0] exp_q[$];
        logic [8:0] e;
        int n;
        exp_q = pay;
        exp_q.push_back(fcs[7:0]);   exp_q.push_back(fcs[15:8]);
        exp_q.push_back(fcs[23:16]); exp_q.push_back(fcs[31:24]);
        n = exp_q.size();
        chk({tag, "_beats"}, rx_q.size() >= n ? n : rx_q.size(), n);
        for (int i = 0; i < n && rx_q.size() > 0; i++) begin
            e = rx_q.pop_front();
            chk($sformatf("%s_data%0d", tag, i), {24'd0, e[7:0]}, {24'd0, exp_q[i]});
            chk($sformatf("%s_last%0d", tag, i), {31'd0, e[8]}, {31'd0, (i == n - 1)});
        end
    endtask

`ifdef FCS_PAD_EN
    function automatic logic [31:0] ref_fcs(input logic [7:0] b[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int k = 0; k < b.size(); k++)
            for (int i = 0; i < 8; i++)
                c = (c[0] ^ b[k][i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return ~c;
    endfunction
`endif

    initial begin
        logic [7:0] f9[$];
        logic [7:0] f1[$];
        int lc1, acc2;
        f9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        f1 = '{8'h00};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_last", {31'd0, m_last}, 32'd0);
        chk("rst_m_data", {24'd0, m_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Check frame "123456789" with m_ready held high
        for (int i = 0; i < 9; i++) begin
            send_byte(f9[i], i == 8);
            if (i == 0) chk("busy_mid", {31'd0, busy}, 32'd1);
        end
        wait_rx(13);
        check_frame("f9", f9, 32'hCBF43926);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("idle_rx_empty", rx_q.size(), 32'd0);

        // Same frame with downstream stalling every other cycle
        toggle_en = 1'b1;
        send_frame(f9);
        wait_rx(13);
        toggle_en = 1'b0;
        check_frame("f9_stall", f9, 32'hCBF43926);
        repeat (3) @(posedge clk);
        #1;

        // Back-to-back frames
        send_frame(f9);
        send_byte(f9[0], 1'b0);
        lc1 = last_cyc;
        acc2 = acc_cyc;
        for (int i = 1; i < 9; i++) send_byte(f9[i], i == 8);
        wait_rx(26);
        chk("b2b_no_bubble", acc2, lc1);
        check_frame("b2b_a", f9, 32'hCBF43926);
        check_frame("b2b_b", f9, 32'hCBF43926);
        repeat (3) @(posedge clk);
        #1;

`ifndef FCS_PAD_EN
        // Single zero byte frame
        send_frame(f1);
        wait_rx(5);
        check_frame("one_byte", f1, 32'hD202EF8D);
        repeat (3) @(posedge clk);
        #1;
`endif

        // Reset in the middle of a frame
        for (int i = 0; i < 5; i++) send_byte(f9[i], 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("midrst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rx_q.delete();
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_no_fcs", rx_q.size(), 32'd0);
        send_frame(f9);
        wait_rx(13);
        check_frame("after_rst", f9, 32'hCBF43926);
        repeat (5) @(posedge clk);
        #1;
        chk("after_rst_extra", rx_q.size(), 32'd0);

`ifdef FCS_PAD_EN
        begin
            logic [7:0] padded[$];
            logic [7:0] f70[$];
            padded = f9;
            for (int i = 0; i < 51; i++) padded.push_back(8'h00);
            send_frame(f9);
            wait_rx(64);
            check_frame("pad60", padded, ref_fcs(padded));
            for (int i = 0; i < 70; i++) f70.push_back(8'(i * 3 + 1));
            send_frame(f70);
            wait_rx(74);
            check_frame("nopad70", f70, ref_fcs(f70));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
